// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: PC/fetch-address control, IF/ID pipeline register and a
// request/response handshake to instruction memory. Optional stall counter via IF_STALL_COUNT_EN.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h00000000,
  parameter logic [31:0] NOP_INSTR = 32'h00000000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        PC_WriteEnable,
  input  logic        IFIDWriteEnable,
  input  logic        IFIDFlush,
  input  logic        Branch,
  input  logic [31:0] BranchDest,
  input  logic        Jump,
  input  logic [31:0] JumpDest,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemValid,
  input  logic [31:0] IMemData,
  output logic [31:0] IFID_Instruction,
  output logic [31:0] IFID_PC,
  output logic        IFID_Valid,
  output logic [31:0] StallCycles
);

  typedef enum logic [1:0] {FETCH, HOLD, DISCARD} state_t;

  localparam logic [31:0] ALIGN_MASK = 32'hFFFFFFFC;
  localparam logic [31:0] RST_PC_AL  = RESET_PC & ALIGN_MASK;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] fetch_addr, fetch_addr_nxt;
  logic [31:0] hold_buf, hold_buf_nxt;
  logic [31:0] ifid_instr_nxt, ifid_pc_nxt;
  logic        ifid_valid_nxt;
  logic        redirect, both_en, load;
  logic [31:0] target_raw, target, pc_inc, load_instr;

  assign IMemReq  = !Reset && (state != HOLD);
  assign IMemAddr = fetch_addr;

  always_comb begin
    redirect       = Branch | Jump;
    target_raw     = Branch ? BranchDest : JumpDest;
    target         = target_raw & ALIGN_MASK;
    pc_inc         = pc + 32'd4;
    both_en        = PC_WriteEnable & IFIDWriteEnable;
    state_nxt      = state;
    pc_nxt         = pc;
    fetch_addr_nxt = fetch_addr;
    hold_buf_nxt   = hold_buf;
    load           = 1'b0;
    load_instr     = hold_buf;

    case (state)
      FETCH: begin
        if (redirect) begin
          pc_nxt       = target;
          hold_buf_nxt = '0;
          if (IMemValid) fetch_addr_nxt = target;
          else           state_nxt      = DISCARD;
        end else if (IMemValid) begin
          if (both_en) begin
            load       = 1'b1;
            load_instr = IMemData;
          end else begin
            hold_buf_nxt = IMemData;
            state_nxt    = HOLD;
          end
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_nxt         = target;
          fetch_addr_nxt = target;
          hold_buf_nxt   = '0;
          state_nxt      = FETCH;
        end else if (both_en) begin
          load      = 1'b1;
          state_nxt = FETCH;
        end
      end
      DISCARD: begin
        // The stale response still has to drain before the new address may go out.
        if (redirect) pc_nxt = target;
        if (IMemValid) begin
          fetch_addr_nxt = redirect ? target : pc;
          state_nxt      = FETCH;
        end
      end
      default: state_nxt = FETCH;
    endcase

    if (load) begin
      pc_nxt         = pc_inc;
      fetch_addr_nxt = pc_inc;
    end

    ifid_instr_nxt = IFID_Instruction;
    ifid_pc_nxt    = IFID_PC;
    ifid_valid_nxt = IFID_Valid;
    if (IFIDFlush) begin
      ifid_instr_nxt = NOP_INSTR;
      ifid_pc_nxt    = pc;
      ifid_valid_nxt = 1'b0;
    end else if (load) begin
      ifid_instr_nxt = load_instr;
      ifid_pc_nxt    = pc;
      ifid_valid_nxt = 1'b1;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state            <= FETCH;
      pc               <= RST_PC_AL;
      fetch_addr       <= RST_PC_AL;
      hold_buf         <= '0;
      IFID_Instruction <= NOP_INSTR;
      IFID_PC          <= RST_PC_AL;
      IFID_Valid       <= 1'b0;
    end else begin
      state            <= state_nxt;
      pc               <= pc_nxt;
      fetch_addr       <= fetch_addr_nxt;
      hold_buf         <= hold_buf_nxt;
      IFID_Instruction <= ifid_instr_nxt;
      IFID_PC          <= ifid_pc_nxt;
      IFID_Valid       <= ifid_valid_nxt;
    end
  end

`ifdef IF_STALL_COUNT_EN
  logic        stall_cyc;
  logic [31:0] stall_cnt;

  assign stall_cyc   = (state == HOLD) || (state == DISCARD) || ((state == FETCH) && !IMemValid);
  assign StallCycles = stall_cnt;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)                                   stall_cnt <= '0;
    else if (stall_cyc && stall_cnt != '1)       stall_cnt <= stall_cnt + 32'd1;
  end
`else
  assign StallCycles = 32'h0;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with a memory model of configurable latency
// (lat=1 answers in the request cycle; address is echoed back as the instruction).
module tb_if_fetch_stage;
  localparam logic [31:0] RST_PC = 32'h00000000;
  localparam logic [31:0] NOP    = 32'h00000013;

  logic        clk = 1'b0, rst = 1'b1;
  logic        pc_we, ifid_we, flush, branch, jump;
  logic [31:0] branch_dest, jump_dest;
  logic        imem_req, imem_valid;
  logic [31:0] imem_addr, imem_data;
  logic [31:0] ifid_instr, ifid_pc, stall_cycles;
  logic        ifid_valid;

  int lat = 1;
  int mcnt;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  if_fetch_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .Clock(clk), .Reset(rst), .PC_WriteEnable(pc_we), .IFIDWriteEnable(ifid_we),
    .IFIDFlush(flush), .Branch(branch), .BranchDest(branch_dest), .Jump(jump),
    .JumpDest(jump_dest), .IMemReq(imem_req), .IMemAddr(imem_addr),
    .IMemValid(imem_valid), .IMemData(imem_data), .IFID_Instruction(ifid_instr),
    .IFID_PC(ifid_pc), .IFID_Valid(ifid_valid), .StallCycles(stall_cycles));

  // Memory: the response comes in the lat-th cycle the request is held.
  assign imem_valid = imem_req && (mcnt == lat - 1);
  assign imem_data  = imem_valid ? imem_addr : 32'hDEADBEEF;

  always @(posedge clk or posedge rst) begin
    if (rst)           mcnt <= 0;
    else if (imem_req) mcnt <= imem_valid ? 0 : mcnt + 1;
    else               mcnt <= 0;
  end

  task automatic idle_inputs();
    pc_we = 1'b1; ifid_we = 1'b1; flush = 1'b0;
    branch = 1'b0; jump = 1'b0; branch_dest = '0; jump_dest = '0;
  endtask

  // Reset for two cycles, released on a falling edge.
  task automatic do_reset(input int l);
    @(negedge clk);
    rst = 1'b1; lat = l; idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; lat = 1; idle_inputs();
    repeat (2) @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem_req); end
    checks++; if (imem_addr !== RST_PC) begin errors++; $display("FAIL reset_addr: got %h want %h", imem_addr, RST_PC); end
    checks++; if ({ifid_instr, ifid_pc, ifid_valid} !== {NOP, RST_PC, 1'b0})
      begin errors++; $display("FAIL reset_ifid: got %h/%h/%b want %h/%h/0", ifid_instr, ifid_pc, ifid_valid, NOP, RST_PC); end
    checks++; if (stall_cycles !== 32'h0) begin errors++; $display("FAIL reset_stall: got %h want 0", stall_cycles); end
    rst = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== RST_PC)
      begin errors++; $display("FAIL first_req: got req=%b addr=%h want 1/%h", imem_req, imem_addr, RST_PC); end
  endtask

  task automatic test_sequential();
    do_reset(1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (ifid_pc !== 32'(4 * i) || ifid_instr !== 32'(4 * i) || ifid_valid !== 1'b1)
        begin errors++; $display("FAIL seq_%0d: got pc=%h instr=%h v=%b want %h/%h/1", i, ifid_pc, ifid_instr, ifid_valid, 4 * i, 4 * i); end
    end
  endtask

  task automatic test_stall();
    do_reset(1);
    repeat (2) @(negedge clk);
    pc_we = 1'b0; ifid_we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 2) begin pc_we = 1'b1; ifid_we = 1'b1; end
      checks++;
      if (ifid_pc !== 32'h4 || imem_req !== 1'b0 || imem_addr !== 32'h8)
        begin errors++; $display("FAIL stall_%0d: got pc=%h req=%b addr=%h want 4/0/8", i, ifid_pc, imem_req, imem_addr); end
    end
    @(negedge clk);
    checks++;
    if (ifid_pc !== 32'h8 || ifid_instr !== 32'h8 || ifid_valid !== 1'b1 || imem_addr !== 32'hC)
      begin errors++; $display("FAIL stall_release: got pc=%h instr=%h v=%b addr=%h want 8/8/1/c", ifid_pc, ifid_instr, ifid_valid, imem_addr); end
    @(negedge clk);
    checks++; if (ifid_pc !== 32'hC || ifid_instr !== 32'hC)
      begin errors++; $display("FAIL stall_next: got pc=%h instr=%h want c/c", ifid_pc, ifid_instr); end
  endtask

  task automatic test_branch_flush();
    branch = 1'b1; branch_dest = 32'h100; flush = 1'b1;
    @(negedge clk);
    idle_inputs();
    checks++;
    if (ifid_instr !== NOP || ifid_valid !== 1'b0 || ifid_pc !== 32'h10)
      begin errors++; $display("FAIL flush_ifid: got %h/%h/%b want %h/10/0", ifid_instr, ifid_pc, ifid_valid, NOP); end
    checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL branch_addr: got %h want 100", imem_addr); end
    @(negedge clk);
    checks++; if (ifid_pc !== 32'h100 || ifid_valid !== 1'b1)
      begin errors++; $display("FAIL branch_target: got pc=%h v=%b want 100/1", ifid_pc, ifid_valid); end
  endtask

  task automatic test_async_reset();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (ifid_valid !== 1'b0 || imem_req !== 1'b0 || ifid_pc !== RST_PC)
      begin errors++; $display("FAIL async_reset: got v=%b req=%b pc=%h want 0/0/%h", ifid_valid, imem_req, ifid_pc, RST_PC); end
  endtask

  task automatic test_jump_latency();
    do_reset(3);
    @(negedge clk);
    jump = 1'b1; jump_dest = 32'h40;
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL jlat_req: got %h want 0", imem_addr); end
    @(negedge clk);
    idle_inputs();
    checks++;
    if (imem_addr !== 32'h0 || imem_req !== 1'b1 || imem_valid !== 1'b1)
      begin errors++; $display("FAIL jlat_discard: got addr=%h req=%b vld=%b want 0/1/1", imem_addr, imem_req, imem_valid); end
    @(negedge clk);
    checks++;
    if (imem_addr !== 32'h40 || ifid_valid !== 1'b0)
      begin errors++; $display("FAIL jlat_dropped: got addr=%h v=%b want 40/0", imem_addr, ifid_valid); end
    repeat (3) @(negedge clk);
    checks++;
    if (ifid_pc !== 32'h40 || ifid_instr !== 32'h40 || ifid_valid !== 1'b1)
      begin errors++; $display("FAIL jlat_target: got %h/%h/%b want 40/40/1", ifid_pc, ifid_instr, ifid_valid); end
  endtask

  task automatic test_priority_wrap();
    do_reset(1);
    @(negedge clk);
    branch = 1'b1; branch_dest = 32'h200; jump = 1'b1; jump_dest = 32'h300;
    @(negedge clk);
    idle_inputs();
    checks++; if (imem_addr !== 32'h200) begin errors++; $display("FAIL prio_addr: got %h want 200", imem_addr); end
    @(negedge clk);
    checks++; if (ifid_pc !== 32'h200) begin errors++; $display("FAIL prio_pc: got %h want 200", ifid_pc); end
    jump = 1'b1; jump_dest = 32'hFFFFFFFE;
    @(negedge clk);
    idle_inputs();
    checks++; if (imem_addr !== 32'hFFFFFFFC) begin errors++; $display("FAIL align_addr: got %h want fffffffc", imem_addr); end
    @(negedge clk);
    checks++;
    if (ifid_pc !== 32'hFFFFFFFC || imem_addr !== 32'h0)
      begin errors++; $display("FAIL wrap_addr: got pc=%h addr=%h want fffffffc/0", ifid_pc, imem_addr); end
    @(negedge clk);
    checks++; if (ifid_pc !== 32'h0 || ifid_valid !== 1'b1)
      begin errors++; $display("FAIL wrap_pc: got pc=%h v=%b want 0/1", ifid_pc, ifid_valid); end
  endtask

  task automatic test_stall_count();
    logic [31:0] exp_stall;
`ifdef IF_STALL_COUNT_EN
    exp_stall = 32'd4;
`else
    exp_stall = 32'd0;
`endif
    do_reset(3);
    repeat (6) @(negedge clk);
    checks++; if (stall_cycles !== exp_stall) begin errors++; $display("FAIL stall_count: got %0d want %0d", stall_cycles, exp_stall); end
    checks++; if (ifid_pc !== 32'h4) begin errors++; $display("FAIL stall_fetch2: got %h want 4", ifid_pc); end
    ifid_we = 1'b0; flush = 1'b1;
    @(negedge clk);
    idle_inputs();
    checks++;
    if (ifid_instr !== NOP || ifid_valid !== 1'b0 || ifid_pc !== 32'h8)
      begin errors++; $display("FAIL flush_over_we: got %h/%h/%b want %h/8/0", ifid_instr, ifid_pc, ifid_valid, NOP); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_sequential();
    test_stall();
    test_branch_flush();
    test_async_reset();
    test_jump_latency();
    test_priority_wrap();
    test_stall_count();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
